input_vc_buffer: RTL and testbench

Per-input-port virtual-channel buffer that sits directly upstream of `route_comp` in each router input port. It receives flits from the link, steers each packet into the VC FIFO named by the head flit's VC class bit, and returns one credit per dequeued flit. It forwards whole packets, with no interleaving, to `route_comp` through a registered output stage that honours `stall`.

---
 rtl/input_vc_buffer.sv | 206 ++++++++++++++++++++
 tb/tb_input_vc_buffer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_vc_buffer.sv
// input_vc_buffer: two-VC input buffer feeding route_comp.
// Ports: clk/rst, flit_in(+valid) from link, stall from downstream;
// flit_out/flit_valid_out/dir_in to route_comp, credit_out per VC,
// overflow_err sticky on a write to a full VC.
module input_vc_buffer #(
  parameter int FLIT_SIZE    = 32,
  parameter int HEADER_LEN   = 2,
  parameter int VC_CLASS_POS = 29,
  parameter int VC_DEPTH     = 8,
  parameter logic [2:0] PORT_DIR = 3'd0,
  parameter logic [HEADER_LEN-1:0] HEAD_FLIT   = 'd0,
  parameter logic [HEADER_LEN-1:0] BODY_FLIT   = 'd1,
  parameter logic [HEADER_LEN-1:0] TAIL_FLIT   = 'd2,
  parameter logic [HEADER_LEN-1:0] SINGLE_FLIT = 'd3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] flit_in,
  input  logic                 flit_in_valid,
  input  logic                 stall,
  output logic [FLIT_SIZE-1:0] flit_out,
  output logic                 flit_valid_out,
  output logic [2:0]           dir_in,
  output logic [1:0]           credit_out,
  output logic                 overflow_err
);

  localparam int PW = $clog2(VC_DEPTH);
  localparam int CW = PW + 1;

  typedef logic [FLIT_SIZE-1:0]  flit_t;
  typedef logic [HEADER_LEN-1:0] ftype_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOCK0 = 2'd1,
    S_LOCK1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_rr;
  logic   w_rr_nxt;
  logic   r_wlock;

  flit_t  w_front [2];
  ftype_t w_ftype [2];
  logic [1:0] w_empty;
  logic [1:0] w_full;
  logic [1:0] w_cand;
  logic [1:0] w_wreq;
  logic [1:0] w_push;
  logic [1:0] w_pop;

  logic   w_grant;
  logic   w_gvc;

  ftype_t w_in_type;
  logic   w_in_hs;
  logic   w_wvc;

  flit_t  r_flit_out;
  logic   r_valid_out;
  logic   r_ovf;

  // Write steering: heads/singles carry their VC, bodies/tails follow
  // the VC of the last head seen on the link.
  assign w_in_type = flit_in[FLIT_SIZE-1 -: HEADER_LEN];
  assign w_in_hs   = (w_in_type == HEAD_FLIT) ||
                     (w_in_type == SINGLE_FLIT);
  assign w_wvc     = w_in_hs ? flit_in[VC_CLASS_POS] : r_wlock;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wlock <= 1'b0;
    end else if (flit_in_valid && (w_in_type == HEAD_FLIT)) begin
      r_wlock <= flit_in[VC_CLASS_POS];
    end
  end

  genvar g;
  for (g = 0; g < 2; g++) begin : g_vc
    flit_t         r_mem [VC_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;

    assign w_front[g] = r_mem[r_rptr];
    assign w_ftype[g] = w_front[g][FLIT_SIZE-1 -: HEADER_LEN];
    assign w_empty[g] = (r_cnt == '0);
    assign w_full[g]  = (r_cnt == CW'(VC_DEPTH));
    assign w_cand[g]  = !w_empty[g] &&
                        ((w_ftype[g] == HEAD_FLIT) ||
                         (w_ftype[g] == SINGLE_FLIT));
    assign w_pop[g]   = w_grant && (w_gvc == 1'(g));
    assign w_wreq[g]  = flit_in_valid && (w_wvc == 1'(g));
    // A pop in the same cycle frees the slot, so a full VC
    // still accepts the write.
    assign w_push[g]  = w_wreq[g] && (!w_full[g] || w_pop[g]);

    always_ff @(posedge clk) begin
      if (w_push[g] && !rst) begin
        r_mem[r_wptr] <= flit_in;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push[g]) begin
          r_wptr <= r_wptr + PW'(1);
        end
        if (w_pop[g]) begin
          r_rptr <= r_rptr + PW'(1);
        end
        unique case ({w_push[g], w_pop[g]})
          2'b10:   r_cnt <= r_cnt + CW'(1);
          2'b01:   r_cnt <= r_cnt - CW'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  // Packet-level arbiter: only heads/singles open a grant while idle;
  // a head locks the output to its VC until the tail leaves.
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_grant     = 1'b0;
    w_gvc       = 1'b0;
    if (!stall) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_cand[r_rr]) begin
            w_grant = 1'b1;
            w_gvc   = r_rr;
          end else if (w_cand[~r_rr]) begin
            w_grant = 1'b1;
            w_gvc   = ~r_rr;
          end
          if (w_grant) begin
            w_rr_nxt = ~w_gvc;
            if (w_ftype[w_gvc] == HEAD_FLIT) begin
              w_state_nxt = w_gvc ? S_LOCK1 : S_LOCK0;
            end
          end
        end
        S_LOCK0, S_LOCK1: begin
          w_gvc = (r_state == S_LOCK1);
          if (!w_empty[w_gvc]) begin
            w_grant = 1'b1;
            if (w_ftype[w_gvc] == TAIL_FLIT) begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flit_out  <= '0;
      r_valid_out <= 1'b0;
    end else if (!stall) begin
      if (w_grant) begin
        r_flit_out  <= w_front[w_gvc];
        r_valid_out <= 1'b1;
      end else begin
        r_valid_out <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (|(w_wreq & w_full & ~w_pop)) begin
      r_ovf <= 1'b1;
    end
  end

  assign flit_out       = r_flit_out;
  assign flit_valid_out = r_valid_out;
  assign credit_out     = rst ? 2'b00 : w_pop;
  assign overflow_err   = r_ovf;
  assign dir_in         = PORT_DIR;

endmodule

// File: tb/tb_input_vc_buffer.sv
// tb_input_vc_buffer: directed + random checks of input_vc_buffer
// against a queue-based packet model.
module tb_input_vc_buffer;

  localparam logic [1:0] HD = 2'd0;
  localparam logic [1:0] BD = 2'd1;
  localparam logic [1:0] TL = 2'd2;
  localparam logic [1:0] SG = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] flit_in = '0;
  logic        flit_in_valid = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] flit_out;
  logic        flit_valid_out;
  logic [2:0]  dir_in;
  logic [1:0]  credit_out;
  logic        overflow_err;

  input_vc_buffer #(
    .FLIT_SIZE(32), .HEADER_LEN(2), .VC_CLASS_POS(29),
    .VC_DEPTH(8), .PORT_DIR(3'd5)
  ) dut (
    .clk(clk), .rst(rst),
    .flit_in(flit_in), .flit_in_valid(flit_in_valid),
    .stall(stall), .flit_out(flit_out),
    .flit_valid_out(flit_valid_out), .dir_in(dir_in),
    .credit_out(credit_out), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  logic [31:0] mq0 [$];
  logic [31:0] mq1 [$];
  int          m_lockv;
  int          m_rr;
  int          m_wlock;
  logic        m_ovf;
  logic [31:0] m_out;
  logic        m_val;
  int          m_pv;

  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    ntests++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic int qsz(int v);
    return (v == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [1:0] ftyp(logic [31:0] f);
    return f[31:30];
  endfunction

  function automatic logic [31:0] mk(logic [1:0] t, logic vc);
    logic [31:0] r;
    r = $urandom;
    r[31:30] = t;
    r[29] = vc;
    return r;
  endfunction

  task automatic model_clear();
    mq0.delete();
    mq1.delete();
    m_lockv = -1;
    m_rr = 0;
    m_wlock = 0;
    m_ovf = 1'b0;
    m_out = '0;
    m_val = 1'b0;
    m_pv = -1;
  endtask

  task automatic decide(logic s);
    logic [31:0] fr;
    int c;
    m_pv = -1;
    if (!s) begin
      if (m_lockv >= 0) begin
        if (qsz(m_lockv) > 0) m_pv = m_lockv;
      end else begin
        for (int k = 0; k < 2; k++) begin
          c = (m_rr + k) % 2;
          if (m_pv < 0 && qsz(c) > 0) begin
            fr = (c == 0) ? mq0[0] : mq1[0];
            if (ftyp(fr) == HD || ftyp(fr) == SG) m_pv = c;
          end
        end
      end
    end
  endtask

  task automatic apply(logic [31:0] f, logic v, logic s);
    logic [31:0] p;
    int t;
    if (!s) begin
      if (m_pv >= 0) begin
        p = (m_pv == 0) ? mq0.pop_front() : mq1.pop_front();
        m_out = p;
        m_val = 1'b1;
        if (m_lockv < 0) begin
          m_rr = 1 - m_pv;
          if (ftyp(p) == HD) m_lockv = m_pv;
        end else if (ftyp(p) == TL) begin
          m_lockv = -1;
        end
      end else begin
        m_val = 1'b0;
      end
    end
    if (v) begin
      if (ftyp(f) == HD || ftyp(f) == SG) t = int'(f[29]);
      else t = m_wlock;
      if (ftyp(f) == HD) m_wlock = int'(f[29]);
      if (qsz(t) >= 8) m_ovf = 1'b1;
      else if (t == 0) mq0.push_back(f);
      else mq1.push_back(f);
    end
  endtask

  task automatic cyc(logic [31:0] f, logic v, logic s);
    logic [1:0] ec;
    flit_in = f;
    flit_in_valid = v;
    stall = s;
    decide(s);
    ec = 2'b00;
    if (m_pv >= 0) ec[m_pv] = 1'b1;
    #2;
    chk("credit", 64'(credit_out), 64'(ec));
    @(posedge clk);
    #1;
    apply(f, v, s);
    chk("valid", 64'(flit_valid_out), 64'(m_val));
    chk("flit", 64'(flit_out), 64'(m_out));
    chk("ovf", 64'(overflow_err), 64'(m_ovf));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flit_in_valid = 1'b0;
    stall = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    chk("rst_valid", 64'(flit_valid_out), 64'(0));
    chk("rst_flit", 64'(flit_out), 64'(0));
    chk("rst_credit", 64'(credit_out), 64'(0));
    chk("rst_ovf", 64'(overflow_err), 64'(0));
    chk("dir", 64'(dir_in), 64'(5));
    rst = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc($urandom, 1'b0, 1'b0);
  endtask

  task automatic pkt(logic vc, int len, logic s);
    if (len == 1) begin
      cyc(mk(SG, vc), 1'b1, s);
    end else begin
      cyc(mk(HD, vc), 1'b1, s);
      for (int i = 1; i < len - 1; i++) cyc(mk(BD, ~vc), 1'b1, s);
      cyc(mk(TL, ~vc), 1'b1, s);
    end
  endtask

  initial begin
    int rem;
    logic cvc;
    logic [31:0] f;
    logic v;
    logic s;

    model_clear();
    do_reset();

    pkt(1'b1, 1, 1'b0);
    idle(4);

    pkt(1'b0, 4, 1'b0);
    idle(6);

    pkt(1'b1, 6, 1'b0);
    for (int i = 0; i < 3; i++) cyc($urandom, 1'b0, 1'b1);
    idle(8);

    do_reset();
    pkt(1'b0, 3, 1'b1);
    pkt(1'b1, 3, 1'b1);
    pkt(1'b0, 1, 1'b1);
    idle(10);

    do_reset();
    for (int i = 0; i < 8; i++) cyc(mk(SG, 1'b0), 1'b1, 1'b1);
    chk("ovf_before", 64'(overflow_err), 64'(0));
    cyc(mk(SG, 1'b0), 1'b1, 1'b1);
    chk("ovf_set", 64'(overflow_err), 64'(1));
    cyc(mk(SG, 1'b0), 1'b1, 1'b0);
    idle(12);

    do_reset();
    cyc(mk(HD, 1'b1), 1'b1, 1'b1);
    cyc(mk(BD, 1'b0), 1'b1, 1'b1);
    cyc(mk(BD, 1'b0), 1'b1, 1'b1);
    do_reset();
    idle(4);

    rem = 0;
    cvc = 1'b0;
    for (int i = 0; i < 400; i++) begin
      f = $urandom;
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 9) < 2);
      if (v) begin
        if (rem == 0) begin
          cvc = 1'($urandom);
          rem = $urandom_range(1, 5);
          f = mk((rem == 1) ? SG : HD, cvc);
          rem = rem - 1;
        end else begin
          rem = rem - 1;
          f = mk((rem == 0) ? TL : BD, 1'($urandom));
        end
      end
      cyc(f, v, s);
    end
    while (rem > 0) begin
      rem = rem - 1;
      cyc(mk((rem == 0) ? TL : BD, 1'b0), 1'b1, 1'b0);
    end
    idle(30);
    chk("drained", 64'(mq0.size() + mq1.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
